// File: rtl/alu32_pkg.sv
// Opcodes and result-entry field widths shared by the ALU pipeline controller.
package alu32_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NOT   = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SHL   = 3'd5;
  localparam logic [2:0] OP_SHR   = 3'd6;
  localparam logic [2:0] OP_TRUNC = 3'd7;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;
  localparam int FLAG_W = 2;

  // Carry-out only has meaning for ADD; every other op reports 0.
  function automatic logic gate_carry(input logic [OP_W-1:0] op, input logic co);
    return (op == OP_ADD) && co;
  endfunction

endpackage

// File: rtl/alu32_pipe_ctrl_if.sv
// Request, ALU-side and result-side signals of the ALU pipeline controller.
interface alu32_pipe_ctrl_if #(
  parameter int TAG_W = 4
);

  logic                          in_valid;
  logic                          in_ready;
  logic [alu32_pkg::DATA_W-1:0]  in1;
  logic [alu32_pkg::DATA_W-1:0]  in2;
  logic                          ci;
  logic [alu32_pkg::OP_W-1:0]    op;
  logic [TAG_W-1:0]              tag;

  logic [alu32_pkg::DATA_W-1:0]  alu_in1;
  logic [alu32_pkg::DATA_W-1:0]  alu_in2;
  logic                          alu_ci;
  logic [alu32_pkg::OP_W-1:0]    alu_a;
  logic [alu32_pkg::DATA_W-1:0]  alu_out;
  logic                          alu_co;

  logic                          out_valid;
  logic                          out_ready;
  logic [alu32_pkg::DATA_W-1:0]  result;
  logic                          carry_out;
  logic                          zero;
  logic [alu32_pkg::OP_W-1:0]    out_op;
  logic [TAG_W-1:0]              out_tag;

  modport slave (
    input  in_valid, in1, in2, ci, op, tag, alu_out, alu_co, out_ready,
    output in_ready, alu_in1, alu_in2, alu_ci, alu_a,
    output out_valid, result, carry_out, zero, out_op, out_tag
  );

  modport master (
    output in_valid, in1, in2, ci, op, tag, alu_out, alu_co, out_ready,
    input  in_ready, alu_in1, alu_in2, alu_ci, alu_a,
    input  out_valid, result, carry_out, zero, out_op, out_tag
  );

endinterface

// File: rtl/alu32_out_fifo.sv
// Generic synchronous circular FIFO; a push is refused when full, a pop when empty.
module alu32_out_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !full_o;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/alu32_pipe_ctrl.sv
// Operand stage feeding an external 32-bit ALU, with flagged results queued for writeback.
module alu32_pipe_ctrl
  import alu32_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int OUT_DEPTH = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  alu32_pipe_ctrl_if.slave bus_if
);

  localparam int ENTRY_W = DATA_W + FLAG_W + OP_W + TAG_W;

  logic              v1_q, v1_d;
  logic [DATA_W-1:0] in1_q, in1_d;
  logic [DATA_W-1:0] in2_q, in2_d;
  logic              ci_q, ci_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  logic               fifo_full, fifo_empty;
  logic               s1_adv, accept, pop;
  logic [ENTRY_W-1:0] push_data, head_data;

  // Only the registered full flag gates S1, so OutReady never reaches InReady.
  assign s1_adv          = v1_q && !fifo_full;
  assign bus_if.in_ready = !rst_i && (!v1_q || s1_adv);
  assign accept          = bus_if.in_valid && bus_if.in_ready;

  always_comb begin
    v1_d  = v1_q;
    in1_d = in1_q;
    in2_d = in2_q;
    ci_d  = ci_q;
    op_d  = op_q;
    tag_d = tag_q;
    if (accept) begin
      v1_d  = 1'b1;
      in1_d = bus_if.in1;
      in2_d = bus_if.in2;
      ci_d  = bus_if.ci;
      op_d  = bus_if.op;
      tag_d = bus_if.tag;
    end else if (s1_adv) begin
      v1_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q  <= 1'b0;
      in1_q <= '0;
      in2_q <= '0;
      ci_q  <= 1'b0;
      op_q  <= '0;
      tag_q <= '0;
    end else begin
      v1_q  <= v1_d;
      in1_q <= in1_d;
      in2_q <= in2_d;
      ci_q  <= ci_d;
      op_q  <= op_d;
      tag_q <= tag_d;
    end
  end

  assign bus_if.alu_in1 = in1_q;
  assign bus_if.alu_in2 = in2_q;
  assign bus_if.alu_ci  = ci_q;
  assign bus_if.alu_a   = op_q;

  assign push_data = {bus_if.alu_out, gate_carry(op_q, bus_if.alu_co),
                      (bus_if.alu_out == '0), op_q, tag_q};

  alu32_out_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (OUT_DEPTH)
  ) u_out_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (s1_adv),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus_if.out_valid = !fifo_empty;
  assign pop              = bus_if.out_valid && bus_if.out_ready;

  assign {bus_if.result, bus_if.carry_out, bus_if.zero, bus_if.out_op, bus_if.out_tag} = head_data;

endmodule

// File: tb/tb_alu32_pipe_ctrl.sv
// Directed and randomized bench for alu32_pipe_ctrl with an external ALU model and result scoreboard.
module tb_alu32_pipe_ctrl;
  import alu32_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        z;
    logic [2:0]  op;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   pop_cnt = 0;
  bit   accepted = 1'b0;
  exp_t exp_q[$];

  alu32_pipe_ctrl_if #(.TAG_W(4)) bus ();

  alu32_pipe_ctrl #(.TAG_W(4), .OUT_DEPTH(2)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the external ALU; carry is the raw adder carry for every op.
  function automatic logic [32:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic ci);
    logic [32:0] sum;
    logic [31:0] r;
    sum = {1'b0, a} + {1'b0, b} + {32'b0, ci};
    r   = '0;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOT:   r = ~a;
      OP_ADD:   r = sum[31:0];
      OP_SHL:   r = a << b[4:0];
      OP_SHR:   r = a >> b[4:0];
      OP_TRUNC: r = a & ~(32'hFFFF_FFFF << b[4:0]);
      default:  r = '0;
    endcase
    return {sum[32], r};
  endfunction

  assign {bus.alu_co, bus.alu_out} = alu_fn(bus.alu_a, bus.alu_in1, bus.alu_in2, bus.alu_ci);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic score();
    exp_t        e;
    logic [32:0] r;
    accepted = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        r     = alu_fn(bus.op, bus.in1, bus.in2, bus.ci);
        e.res = r[31:0];
        e.co  = (bus.op == OP_ADD) ? r[32] : 1'b0;
        e.z   = (r[31:0] == 32'h0);
        e.op  = bus.op;
        e.tag = bus.tag;
        exp_q.push_back(e);
        acc_cnt++;
        accepted = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", 64'(bus.out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("result_entry",
              64'({bus.result, bus.carry_out, bus.zero, bus.out_op, bus.out_tag}), 64'(e));
          pop_cnt++;
        end
      end
    end
  endtask

  task automatic step();
    #1;
    score();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input bit v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic ci, input logic [3:0] tag);
    bus.in_valid = v;
    bus.op       = op;
    bus.in1      = a;
    bus.in2      = b;
    bus.ci       = ci;
    bus.tag      = tag;
  endtask

  task automatic rand_req(input logic [3:0] tag);
    set_req(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)), tag);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int p0;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    set_req(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 4'd0);

    // Reset held for two edges.
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    chk("rst_in_ready2", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid2", 64'(bus.out_valid), 64'(0));
    chk("rst_data", 64'({bus.result, bus.carry_out, bus.zero, bus.out_op, bus.out_tag}), 64'(0));
    chk("rst_alu", 64'({bus.alu_in1, bus.alu_ci, bus.alu_a}), 64'(0));
    chk("rst_alu_in2", 64'(bus.alu_in2), 64'(0));
    rst = 1'b0;
    #1;
    chk("release_in_ready", 64'(bus.in_ready), 64'(1));

    // ADD overflowing to zero.
    bus.out_ready = 1'b1;
    set_req(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'd5);
    step();
    bus.in_valid = 1'b0;
    chk("add_out_valid_early", 64'(bus.out_valid), 64'(0));
    chk("add_alu_a", 64'(bus.alu_a), 64'(OP_ADD));
    chk("add_alu_in1", 64'(bus.alu_in1), 64'(32'hFFFF_FFFF));
    step();
    chk("add_out_valid", 64'(bus.out_valid), 64'(1));
    chk("add_result", 64'(bus.result), 64'(0));
    chk("add_flags", 64'({bus.carry_out, bus.zero}), 64'(2'b11));
    chk("add_op_tag", 64'({bus.out_op, bus.out_tag}), 64'({3'd4, 4'd5}));

    // AND with carry-in set: adder carry must be gated off.
    set_req(1'b1, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 4'd3);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("and_out_valid", 64'(bus.out_valid), 64'(1));
    chk("and_result", 64'(bus.result), 64'(32'hF000_F000));
    chk("and_flags", 64'({bus.carry_out, bus.zero}), 64'(2'b00));
    drain(20);

    // Eight back-to-back requests with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      rand_req(4'(i));
      chk("b2b_in_ready", 64'(bus.in_ready), 64'(1));
      step();
      chk("b2b_out_valid", 64'(bus.out_valid), 64'(i >= 1));
    end
    bus.in_valid = 1'b0;
    step();
    chk("b2b_tail_valid", 64'(bus.out_valid), 64'(1));
    step();
    chk("b2b_tail_empty", 64'(bus.out_valid), 64'(0));
    drain(10);

    // Backpressure: S1 plus two FIFO entries fill, then InReady drops.
    bus.out_ready = 1'b0;
    p0  = pop_cnt;
    idx = 0;
    rand_req(4'd8);
    for (int c = 0; c < 6; c++) begin
      step();
      if (accepted) begin
        idx++;
        if (idx < 5) rand_req(4'(8 + idx));
        else bus.in_valid = 1'b0;
      end
    end
    chk("bp_accepted", 64'(idx), 64'(3));
    chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
    chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      step();
      if (accepted) begin
        idx++;
        if (idx < 5) rand_req(4'(8 + idx));
        else bus.in_valid = 1'b0;
      end
    end
    chk("bp_all_accepted", 64'(idx), 64'(5));
    drain(20);
    chk("bp_pops", 64'(pop_cnt - p0), 64'(5));

    // Reset with two results queued discards them.
    bus.out_ready = 1'b0;
    rand_req(4'd1);
    step();
    rand_req(4'd2);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("pre_rst_valid", 64'(bus.out_valid), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("post_rst_result", 64'(bus.result), 64'(0));
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    bus.out_ready = 1'b1;
    p0 = pop_cnt;
    set_req(1'b1, OP_ADD, 32'h1234_0000, 32'h0000_5678, 1'b1, 4'd9);
    step();
    drain(10);
    chk("post_rst_pops", 64'(pop_cnt - p0), 64'(1));

    // Random traffic with random consumer stalls.
    for (int c = 0; c < 300; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid || accepted) begin
        if ($urandom_range(0, 3) != 0) rand_req(4'($urandom_range(0, 15)));
        else bus.in_valid = 1'b0;
      end
      step();
    end
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
